// File: rtl/synth_pkg.sv
// Shared types for the synthesizer octave-select front end.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MUTE_PRE  = 2'd1,
    APPLY     = 2'd2,
    MUTE_POST = 2'd3
  } oct_state_t;

  localparam int NUM_OCT_DEF = 4;
  localparam int OCT_W       = $clog2(NUM_OCT_DEF);

  typedef logic [OCT_W-1:0] oct_idx_t;

endpackage

// File: rtl/button_debounce.sv
// Raw button to clean one-cycle press pulse: 2-FF sync, consecutive-cycle
// debounce counter on the accepted level, registered rising-edge detect.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      // Any cycle agreeing with the accepted level restarts the count.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= ~level_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/octave_controller.sv
// Octave-select sequencer: debounced up/down presses step a saturating index,
// each change bracketed by mute windows so the divider bank switches silently.
module octave_controller
  import synth_pkg::*;
#(
  parameter int NUM_OCT         = NUM_OCT_DEF,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MUTE_CYCLES     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       oct_up_btn,
  input  logic                       oct_down_btn,
  output logic [$clog2(NUM_OCT)-1:0] oct_sel,
  output logic                       mute,
  output logic                       oct_changed,
  output logic                       busy
);

  localparam int SEL_W  = $clog2(NUM_OCT);
  localparam int MCNT_W = $clog2(MUTE_CYCLES + 1);

  logic              up_press, dn_press;
  logic              req_up, req_dn;
  oct_state_t        state_q, state_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              dir_dn_q, dir_dn_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              mute_q, busy_q, chg_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (oct_up_btn),
    .press_o (up_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_db (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (oct_down_btn),
    .press_o (dn_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcnt_q   <= '0;
      dir_dn_q <= 1'b0;
      sel_q    <= '0;
      mute_q   <= 1'b0;
      busy_q   <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      dir_dn_q <= dir_dn_d;
      sel_q    <= sel_d;
      mute_q   <= (state_d != IDLE);
      busy_q   <= (state_d != IDLE);
      chg_q    <= (state_d == APPLY);
    end
  end

  always_comb begin
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    dir_dn_d = dir_dn_q;
    sel_d    = sel_q;
    // Simultaneous presses cancel; requests past either end are dropped.
    req_dn   = dn_press & ~up_press & (sel_q != SEL_W'(NUM_OCT - 1));
    req_up   = up_press & ~dn_press & (sel_q != '0);
    case (state_q)
      IDLE: begin
        if (req_dn || req_up) begin
          state_d  = MUTE_PRE;
          mcnt_d   = '0;
          dir_dn_d = req_dn;
        end
      end
      MUTE_PRE: begin
        if (mcnt_q == MCNT_W'(MUTE_CYCLES - 1)) begin
          state_d = APPLY;
          sel_d   = dir_dn_q ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
        end else begin
          mcnt_d = mcnt_q + MCNT_W'(1);
        end
      end
      APPLY: begin
        state_d = MUTE_POST;
        mcnt_d  = '0;
      end
      MUTE_POST: begin
        if (mcnt_q == MCNT_W'(MUTE_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          mcnt_d = mcnt_q + MCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign oct_sel     = sel_q;
  assign mute        = mute_q;
  assign busy        = busy_q;
  assign oct_changed = chg_q;

endmodule

// File: tb/tb_octave_controller.sv
// Directed bench for octave_controller with NUM_OCT=4, DEBOUNCE_CYCLES=4,
// MUTE_CYCLES=3.
module tb_octave_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_btn, dn_btn;
  logic [1:0] oct_sel;
  logic       mute, oct_changed, busy;

  int total = 0;
  int bad   = 0;

  int   m_rise, m_high, m_chg, m_chg_pos, m_busy_diff, run;
  logic prev_mute;

  octave_controller #(
    .NUM_OCT         (4),
    .DEBOUNCE_CYCLES (4),
    .MUTE_CYCLES     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .oct_up_btn   (up_btn),
    .oct_down_btn (dn_btn),
    .oct_sel      (oct_sel),
    .mute         (mute),
    .oct_changed  (oct_changed),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    m_rise = 0; m_high = 0; m_chg = 0; m_chg_pos = 0; m_busy_diff = 0; run = 0;
    prev_mute = mute;
  endtask

  // Advance one clock and sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (mute === 1'b1 && prev_mute !== 1'b1) m_rise++;
    if (mute === 1'b1) begin
      m_high++;
      run++;
    end else begin
      run = 0;
    end
    if (oct_changed === 1'b1) begin
      m_chg++;
      m_chg_pos = run;
    end
    if (busy !== mute) m_busy_diff++;
    prev_mute = mute;
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst    = 1'b1;
    up_btn = 1'b0;
    dn_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oct_sel", oct_sel, 0);
    chk("rst_mute", mute, 0);
    chk("rst_changed", oct_changed, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Clean down press: pulse after edge 7, mute after edges 8..14, apply at 11.
    clr_mon();
    dn_btn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("clean_mute_%0d", k), mute, (k >= 8 && k <= 14));
      chk($sformatf("clean_chg_%0d", k), oct_changed, (k == 11));
      chk($sformatf("clean_sel_%0d", k), oct_sel, (k >= 11) ? 1 : 0);
    end
    dn_btn = 1'b0;
    watch(15);
    chk("clean_mute_len", m_high, 7);
    chk("clean_chg_pos", m_chg_pos, 4);
    chk("clean_busy_mirror", m_busy_diff, 0);
    chk("clean_chg_count", m_chg, 1);

    // Bouncy down press, then held.
    clr_mon();
    for (int i = 0; i < 10; i++) begin
      dn_btn = ((i / 2) % 2 == 0);
      step();
    end
    dn_btn = 1'b1;
    watch(30);
    dn_btn = 1'b0;
    watch(15);
    chk("bounce_seq", m_rise, 1);
    chk("bounce_chg", m_chg, 1);
    chk("bounce_len", m_high, 7);
    chk("bounce_sel", oct_sel, 2);

    // Down to the last octave.
    clr_mon();
    dn_btn = 1'b1;
    watch(30);
    dn_btn = 1'b0;
    watch(15);
    chk("dn3_seq", m_rise, 1);
    chk("dn3_sel", oct_sel, 3);

    // Saturation at the top index.
    clr_mon();
    dn_btn = 1'b1;
    watch(30);
    dn_btn = 1'b0;
    watch(15);
    chk("sat_dn_mute", m_rise, 0);
    chk("sat_dn_chg", m_chg, 0);
    chk("sat_dn_sel", oct_sel, 3);

    // Three up presses back to index 0.
    for (int j = 0; j < 3; j++) begin
      clr_mon();
      up_btn = 1'b1;
      watch(30);
      up_btn = 1'b0;
      watch(15);
      chk($sformatf("up_seq_%0d", j), m_rise, 1);
      chk($sformatf("up_chg_pos_%0d", j), m_chg_pos, 4);
      chk($sformatf("up_sel_%0d", j), oct_sel, 2 - j);
    end

    // Saturation at index 0.
    clr_mon();
    up_btn = 1'b1;
    watch(30);
    up_btn = 1'b0;
    watch(15);
    chk("sat_up_mute", m_rise, 0);
    chk("sat_up_chg", m_chg, 0);
    chk("sat_up_sel", oct_sel, 0);

    // Up press pulse lands in the first MUTE_POST cycle of a down sequence.
    clr_mon();
    dn_btn = 1'b1;
    watch(5);
    up_btn = 1'b1;
    watch(40);
    dn_btn = 1'b0;
    up_btn = 1'b0;
    watch(15);
    chk("busy_drop_seq", m_rise, 1);
    chk("busy_drop_chg", m_chg, 1);
    chk("busy_drop_sel", oct_sel, 1);

    // Both buttons together from IDLE.
    clr_mon();
    dn_btn = 1'b1;
    up_btn = 1'b1;
    watch(30);
    dn_btn = 1'b0;
    up_btn = 1'b0;
    watch(15);
    chk("both_mute", m_rise, 0);
    chk("both_sel", oct_sel, 1);

    // Reset in the second MUTE_PRE cycle.
    clr_mon();
    dn_btn = 1'b1;
    watch(9);
    chk("midrst_pre_mute", mute, 1);
    chk("midrst_pre_chg", m_chg, 0);
    rst = 1'b1;
    #1;
    chk("midrst_mute", mute, 0);
    chk("midrst_sel", oct_sel, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_chg", oct_changed, 0);
    dn_btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clr_mon();
    watch(40);
    chk("postrst_chg", m_chg, 0);
    chk("postrst_mute", m_rise, 0);
    chk("postrst_sel", oct_sel, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
